mem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the single-port synchronous memory shared by the 16-bit processor and a second bus master (DMA engine or debug loader). It accepts one request at a time and drives the memory's address, data and write-enable from registers. It honours the memory's one-cycle read latency and returns read data to the owning master with a per-master valid strobe. Arbitration is round-robin, so neither master can starve the other.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the two-master memory arbiter.
//   - arb_state_e : sequencer state encoding (IDLE, WR, RD, RV)
//   - AW_DEF/DW_DEF : default address / data widths
//   - M0/M1 : master index constants, also used as the winner encoding
package mem_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RV   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: master-side bus of the two-master memory arbiter.
//   Request side (driven by masters): req0/1, we0/1, addr0/1, wdata0/1
//   Response side (driven by arbiter): gnt0/1, rvalid0/1, rdata (shared)
// Modports:
//   master - the bus masters (processor, DMA/debug loader)
//   slave  - the arbiter
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin winner selection.
// Ports:
//   req0, req1 (in)  - request lines
//   prio       (in)  - master that wins when both request
//   valid      (out) - at least one request is present
//   w          (out) - winning master index (M0/M1); meaningful when valid
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic w
);

  assign valid = req0 | req1;
  // Contested: prio decides. Uncontested: the lone requester (M1 iff req1).
  assign w = (req0 & req1) ? prio : (req1 ? M1 : M0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter/sequencer for a single-port synchronous
// memory with one-cycle read latency.
// Ports:
//   Clock     (in)  - system clock, rising edge
//   Resetn    (in)  - synchronous active-low reset
//   bus       (slave modport) - master requests, grants, read strobes, rdata
//   mem_addr  (out) - registered memory address
//   mem_wdata (out) - registered memory write data
//   mem_wren  (out) - registered memory write enable
//   mem_q     (in)  - memory read data, valid one cycle after the address edge
// One access is in flight at a time: a write takes IDLE->WR, a read takes
// IDLE->RD->RV. Requests are only looked at in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)(
  input  logic          Clock,
  input  logic          Resetn,
  mem_arbiter_if.slave  bus,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  arb_state_e    state_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic          mem_wren_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          owner_q;
  logic          prio_q;

  logic          pick_valid;
  logic          pick_w;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .prio  (prio_q),
    .valid (pick_valid),
    .w     (pick_w)
  );

  // Winner's request fields.
  assign sel_we    = pick_w ? bus.we1    : bus.we0;
  assign sel_addr  = pick_w ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick_w ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      // In-flight accesses are dropped; a write already in WR has had
      // mem_wren high up to this edge, so the memory still commits it.
      state_q     <= IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= M0;
      prio_q      <= M0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      mem_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_wren_q  <= sel_we;
            owner_q     <= pick_w;
            // Granted master drops to lowest priority, contested or not.
            prio_q      <= ~pick_w;
            gnt0_q      <= (pick_w == M0);
            gnt1_q      <= (pick_w == M1);
            state_q     <= sel_we ? WR : RD;
          end
        end
        WR: begin
          state_q <= IDLE;
        end
        RD: begin
          // Memory captures mem_addr at this edge; its data shows in RV.
          rvalid0_q <= (owner_q == M0);
          rvalid1_q <= (owner_q == M1);
          state_q   <= RV;
        end
        RV: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = mem_q;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus, a transaction-level
// reference model compared every cycle, plus literal expectations.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_q     (mem_q)
  );

  always #5 Clock = ~Clock;

  // ---------------- memory device (256 words) ----------------
  logic [DW-1:0] mem [256];
  bit            mem_ready;
  always @(posedge Clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h40] <= 16'hBEEF;
      mem_ready  <= 1'b1;
    end else if (mem_wren) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_q <= mem[mem_addr[7:0]];
  end

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Schedule model: a grant decided in cycle c shows in c+1; a read's data
  // strobe shows in c+2; the arbiter is deaf for 1 (write) or 2 (read)
  // cycles after the grant cycle.
  logic [DW-1:0] shadow [256];
  bit            sh_ready;
  bit            m_ok;
  logic          m_prio;
  int            m_busy;
  int            m_rd_cd;
  logic          m_rd_own;
  logic [7:0]    m_rd_a;
  logic          m_w, m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic          e_gnt0, e_gnt1, e_rv0, e_rv1, e_wren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  always @(negedge Clock) begin
    if (!sh_ready) begin
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      shadow[8'h40] = 16'hBEEF;
      sh_ready = 1'b1;
    end
    if (m_ok) begin
      chk("gnt0", bus.gnt0, e_gnt0);
      chk("gnt1", bus.gnt1, e_gnt1);
      chk("rvalid0", bus.rvalid0, e_rv0);
      chk("rvalid1", bus.rvalid1, e_rv1);
      chk("mem_wren", mem_wren, e_wren);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      if (e_rv0 || e_rv1) chk("rdata", bus.rdata, e_rdata);
    end
    e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_wren = 1'b0;
    if (!Resetn) begin
      e_addr = '0; e_wdata = '0; m_prio = 1'b0;
      m_busy = 0; m_rd_cd = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_rd_cd > 0) begin
        m_rd_cd--;
        if (m_rd_cd == 0) begin
          if (m_rd_own) e_rv1 = 1'b1; else e_rv0 = 1'b1;
          e_rdata = shadow[m_rd_a];
        end
      end
      if (m_busy > 0) begin
        m_busy--;
      end else if (bus.req0 || bus.req1) begin
        m_w  = (bus.req0 && bus.req1) ? m_prio : bus.req1;
        m_a  = m_w ? bus.addr1  : bus.addr0;
        m_d  = m_w ? bus.wdata1 : bus.wdata0;
        m_we = m_w ? bus.we1    : bus.we0;
        if (m_w) e_gnt1 = 1'b1; else e_gnt0 = 1'b1;
        e_addr  = m_a;
        e_wdata = m_d;
        if (m_we) begin
          e_wren = 1'b1;
          shadow[m_a[7:0]] = m_d;
          m_busy = 1;
        end else begin
          m_rd_cd  = 1;
          m_rd_own = m_w;
          m_rd_a   = m_a[7:0];
          m_busy   = 2;
        end
        m_prio = ~m_w;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit m, input bit r, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic wait_gnt(input bit m, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      cyc++;
      if ((m ? bus.gnt1 : bus.gnt0) === 1'b1) ok = 1'b1;
    end
    chk($sformatf("gnt%0d_seen", m), {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rv(input bit m, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      cyc++;
      if ((m ? bus.rvalid1 : bus.rvalid0) === 1'b1) ok = 1'b1;
    end
    chk($sformatf("rvalid%0d_seen", m), {31'd0, ok}, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c;
    int g0, wr_cnt, rv_cnt, cnt0;
    bit order [$];
    int k, j;

    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    Resetn = 1'b0;
    repeat (2) tick();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_mem_addr", mem_addr, 0);
    Resetn = 1'b1;
    tick();

    // Single read by master 1
    drive(1, 1, 0, 16'h0040, '0);
    wait_gnt(1, c);
    chk("rd_gnt_latency", c, 1);
    chk("rd_mem_addr", mem_addr, 16'h0040);
    drive(1, 0, 0, '0, '0);
    wait_rv(1, c);
    chk("rd_rv_latency", c, 1);
    chk("rd_rdata", bus.rdata, 16'hBEEF);
    chk("rd_rvalid0", bus.rvalid0, 0);
    tick();

    // Write by master 0 then read back
    drive(0, 1, 1, 16'h0010, 16'h1234);
    wait_gnt(0, c);
    chk("wr_wren", mem_wren, 1);
    chk("wr_addr", mem_addr, 16'h0010);
    chk("wr_wdata", mem_wdata, 16'h1234);
    drive(0, 0, 0, '0, '0);
    tick();
    chk("wr_wren_pulse", mem_wren, 0);
    drive(0, 1, 0, 16'h0010, '0);
    wait_gnt(0, c);
    drive(0, 0, 0, '0, '0);
    wait_rv(0, c);
    chk("wr_readback", bus.rdata, 16'h1234);
    tick();

    // Contention fairness from reset
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    k = 0; j = 0;
    drive(0, 1, 1, 16'h0020, 16'hA000);
    drive(1, 1, 0, 16'h0020, '0);
    for (int i = 0; i < 100 && order.size() < 8; i++) begin
      tick();
      if (bus.gnt0 === 1'b1) begin
        order.push_back(1'b0);
        k++;
        drive(0, 1, 1, 16'h0020 + 16'(k), 16'hA000 + 16'(k));
      end
      if (bus.gnt1 === 1'b1) begin
        order.push_back(1'b1);
        j++;
        drive(1, 1, 0, 16'h0020 + 16'(j), '0);
      end
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    chk("fair_grants", order.size(), 8);
    cnt0 = 0;
    foreach (order[i]) begin
      chk($sformatf("fair_order%0d", i), {31'd0, order[i]}, i % 2);
      if (order[i] == 1'b0) cnt0++;
    end
    chk("fair_m0_count", cnt0, 4);
    repeat (4) tick();

    // Request withdrawal: req0 raised in RD, dropped in RV
    drive(1, 1, 0, 16'h0040, '0);
    wait_gnt(1, c);
    drive(1, 0, 0, '0, '0);
    drive(0, 1, 1, 16'h0050, 16'hDEAD);
    g0 = 0; wr_cnt = 0;
    tick();
    chk("wd_rvalid1", bus.rvalid1, 1);
    if (bus.gnt0 === 1'b1) g0++;
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.gnt0 === 1'b1) g0++;
      if (mem_wren === 1'b1) wr_cnt++;
    end
    chk("wd_no_gnt0", g0, 0);
    chk("wd_no_write", wr_cnt, 0);
    chk("wd_mem50", mem[8'h50], 16'h0000);

    // Reset mid-read
    drive(0, 1, 0, 16'h0040, '0);
    wait_gnt(0, c);
    drive(0, 0, 0, '0, '0);
    Resetn = 1'b0;
    tick();
    chk("rr_gnt0", bus.gnt0, 0);
    chk("rr_gnt1", bus.gnt1, 0);
    chk("rr_rvalid0", bus.rvalid0, 0);
    chk("rr_rvalid1", bus.rvalid1, 0);
    chk("rr_wren", mem_wren, 0);
    chk("rr_addr", mem_addr, 0);
    chk("rr_wdata", mem_wdata, 0);
    Resetn = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) rv_cnt++;
    end
    chk("rr_no_rvalid", rv_cnt, 0);
    drive(0, 1, 0, 16'h0040, '0);
    drive(1, 1, 0, 16'h0010, '0);
    tick();
    chk("rr_prio_gnt0", bus.gnt0, 1);
    chk("rr_prio_gnt1", bus.gnt1, 0);
    drive(0, 0, 0, '0, '0);
    wait_gnt(1, c);
    drive(1, 0, 0, '0, '0);
    repeat (3) tick();

    // Back-to-back write then read by master 0
    drive(0, 1, 1, 16'h0070, 16'h5A5A);
    wait_gnt(0, c);
    chk("b2b_wr_latency", c, 1);
    drive(0, 1, 0, 16'h0070, '0);
    tick();
    chk("b2b_idle_gnt0", bus.gnt0, 0);
    tick();
    chk("b2b_rd_gnt0", bus.gnt0, 1);
    drive(0, 0, 0, '0, '0);
    tick();
    chk("b2b_rvalid0", bus.rvalid0, 1);
    chk("b2b_rdata", bus.rdata, 16'h5A5A);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
